// File: rtl/bp_mc_mmio_arbiter.sv
// rtl/bp_mc_mmio_arbiter.sv - round-robin sharing of one MMIO bridge port among BedRock requesters
//
// Shares one manycore MMIO bridge command/response port among num_req_p uncached requesters.
// Commands are arbitrated round-robin. Each granted requester id goes into an in-order tag FIFO,
// so the bridge's in-order responses can be steered back to the requester that issued them.
// Per-requester and global in-flight limits are enforced, and a drain control blocks new grants.
//
// Optional build macro: BP_MC_MMIO_ARB_STATS_EN adds per-requester saturating grant counters.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   req_i / req_v_i         requester commands (requester r at slice r) and valids
//   req_ready_o             per-requester grant (valid-and-ready handshake)
//   resp_o / resp_v_o       response broadcast to all requesters, one-hot valid
//   resp_yumi_i             per-requester response consume
//   cmd_o / cmd_v_o         command to the bridge, with its valid
//   cmd_ready_i             bridge ready
//   resp_i / resp_v_i       bridge response and its valid
//   resp_yumi_o             bridge response consume
//   drain_i / drain_done_o  block new grants / drain requested and nothing in flight
//   outstanding_o           global in-flight count
//   stats_clr_i             (stats build only) clear all grant counters
//   grant_count_o           (stats build only) 32-bit grant counter per requester
module bp_mc_mmio_arbiter #(
  parameter int num_req_p = 2,
  parameter int msg_width_p = 64,
  parameter int max_outstanding_p = 32,
  parameter int max_per_req_p = 8,
  localparam int lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1,
  localparam int out_width_lp = $clog2(max_outstanding_p + 1),
  localparam int cnt_width_lp = $clog2(max_per_req_p + 1),
  localparam int ptr_width_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p*msg_width_p-1:0] req_i,
  input  logic [num_req_p-1:0]             req_v_i,
  output logic [num_req_p-1:0]             req_ready_o,
  output logic [msg_width_p-1:0]           resp_o,
  output logic [num_req_p-1:0]             resp_v_o,
  input  logic [num_req_p-1:0]             resp_yumi_i,
  output logic [msg_width_p-1:0]           cmd_o,
  output logic                             cmd_v_o,
  input  logic                             cmd_ready_i,
  input  logic [msg_width_p-1:0]           resp_i,
  input  logic                             resp_v_i,
  output logic                             resp_yumi_o,
  input  logic                             drain_i,
  output logic                             drain_done_o,
  output logic [out_width_lp-1:0]          outstanding_o
`ifdef BP_MC_MMIO_ARB_STATS_EN
  ,
  input  logic                             stats_clr_i,
  output logic [num_req_p*32-1:0]          grant_count_o
`endif
);

  localparam logic [out_width_lp-1:0]  max_out_lp    = out_width_lp'(max_outstanding_p);
  localparam logic [cnt_width_lp-1:0]  max_cnt_lp    = cnt_width_lp'(max_per_req_p);
  localparam logic [lg_num_req_lp:0]   num_req_w_lp  = (lg_num_req_lp + 1)'(num_req_p);
  localparam logic [lg_num_req_lp-1:0] last_req_lp   = lg_num_req_lp'(num_req_p - 1);
  localparam logic [ptr_width_lp-1:0]  last_ptr_lp   = ptr_width_lp'(max_outstanding_p - 1);

  logic [lg_num_req_lp-1:0] rr_ptr_r;
  logic [cnt_width_lp-1:0]  cnt_r [num_req_p];
  logic [out_width_lp-1:0]  outstanding_r;
  logic [lg_num_req_lp-1:0] tag_mem_r [max_outstanding_p];
  logic [ptr_width_lp-1:0]  rd_ptr_r, wr_ptr_r;

  logic [msg_width_p-1:0]   req_msgs [num_req_p];
  logic [num_req_p-1:0]     eligible;
  logic                     grant_found;
  logic [lg_num_req_lp-1:0] grant_id;
  logic                     cmd_fire;
  logic                     tag_v;
  logic [lg_num_req_lp-1:0] head_tag;
  logic                     resp_valid;

  // The in-flight count equals the tag FIFO occupancy, so it doubles as the FIFO fill level.
  // Eligibility requires it below the depth, so a full FIFO is never written (no bypass).
  always_comb begin
    for (int r = 0; r < num_req_p; r++) begin
      req_msgs[r] = req_i[r*msg_width_p +: msg_width_p];
      eligible[r] = req_v_i[r] & (cnt_r[r] < max_cnt_lp) & (outstanding_r < max_out_lp)
                    & ~drain_i & ~reset_i;
    end
  end

  // The first eligible requester at or after the RR pointer, wrapping.
  always_comb begin
    logic [lg_num_req_lp:0] cand;
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int i = 0; i < num_req_p; i++) begin
      cand = {1'b0, rr_ptr_r} + (lg_num_req_lp + 1)'(i);
      if (cand >= num_req_w_lp) cand = cand - num_req_w_lp;
      if (!grant_found && eligible[cand[lg_num_req_lp-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = cand[lg_num_req_lp-1:0];
      end
    end
  end

  assign cmd_v_o  = grant_found;
  assign cmd_o    = req_msgs[grant_id];
  assign cmd_fire = grant_found & cmd_ready_i;

  always_comb begin
    req_ready_o = '0;
    if (cmd_fire) req_ready_o[grant_id] = 1'b1;
  end

  assign tag_v      = (outstanding_r != '0);
  assign head_tag   = tag_mem_r[rd_ptr_r];
  assign resp_valid = resp_v_i & tag_v & ~reset_i;
  assign resp_o     = resp_i;
  assign resp_yumi_o = resp_valid & resp_yumi_i[head_tag];

  always_comb begin
    resp_v_o = '0;
    if (resp_valid) resp_v_o[head_tag] = 1'b1;
  end

  assign outstanding_o = outstanding_r;
  assign drain_done_o  = drain_i & (outstanding_r == '0) & ~reset_i;

  always_ff @(posedge clk_i) begin
    if (cmd_fire) tag_mem_r[wr_ptr_r] <= grant_id;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr_r      <= '0;
      outstanding_r <= '0;
      rd_ptr_r      <= '0;
      wr_ptr_r      <= '0;
      for (int r = 0; r < num_req_p; r++) cnt_r[r] <= '0;
    end else begin
      if (cmd_fire) begin
        wr_ptr_r <= (wr_ptr_r == last_ptr_lp) ? '0 : wr_ptr_r + 1'b1;
        rr_ptr_r <= (grant_id == last_req_lp) ? '0 : grant_id + 1'b1;
      end
      if (resp_yumi_o) rd_ptr_r <= (rd_ptr_r == last_ptr_lp) ? '0 : rd_ptr_r + 1'b1;
      if (cmd_fire && !resp_yumi_o) outstanding_r <= outstanding_r + 1'b1;
      else if (!cmd_fire && resp_yumi_o) outstanding_r <= outstanding_r - 1'b1;
      // A grant and a response for the same requester in one cycle cancel out.
      for (int r = 0; r < num_req_p; r++) begin
        if ((cmd_fire && grant_id == lg_num_req_lp'(r)) && !(resp_yumi_o && head_tag == lg_num_req_lp'(r)))
          cnt_r[r] <= cnt_r[r] + 1'b1;
        else if (!(cmd_fire && grant_id == lg_num_req_lp'(r)) && (resp_yumi_o && head_tag == lg_num_req_lp'(r)))
          cnt_r[r] <= cnt_r[r] - 1'b1;
      end
    end
  end

`ifdef BP_MC_MMIO_ARB_STATS_EN
  logic [31:0] grant_cnt_r [num_req_p];

  // Clear wins over a same-cycle grant; counters stick at all-ones.
  always_ff @(posedge clk_i) begin
    for (int r = 0; r < num_req_p; r++) begin
      if (reset_i || stats_clr_i) grant_cnt_r[r] <= '0;
      else if (cmd_fire && grant_id == lg_num_req_lp'(r) && grant_cnt_r[r] != 32'hFFFF_FFFF)
        grant_cnt_r[r] <= grant_cnt_r[r] + 32'd1;
    end
  end

  always_comb begin
    for (int r = 0; r < num_req_p; r++) grant_count_o[r*32 +: 32] = grant_cnt_r[r];
  end
`endif

`ifndef SYNTHESIS
  // A bridge response with nothing in flight means the bridge and arbiter are out of step.
  a_resp_without_tag: assert property (@(posedge clk_i) disable iff (reset_i) !(resp_v_i && !tag_v));
  a_cnt_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
                                    !(resp_yumi_o && cnt_r[head_tag] == '0));
`endif

endmodule
